// File: rtl/fp_operand_unpack_pipe.sv
// fp_operand_unpack_pipe
// Two-stage IEEE-754 operand unpacker that feeds the add/sub datapath.
// Stage 1 captures the packed operand pair. Stage 2 registers the decoded view:
// signs, effective exponents, mantissas with the hidden bit, class flags,
// magnitude ordering and the alignment shift.
// Both sides use a valid/ready handshake. Each stage advances when its
// successor is empty or advancing, so back-to-back pairs flow without bubbles.
module fp_operand_unpack_pipe #(
    parameter int EXP_W   = 8,
    parameter int FRAC_W  = 23,
    parameter bit SWAP_EN = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [EXP_W+FRAC_W:0]     x_i,
    input  logic [EXP_W+FRAC_W:0]     y_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      big_sign_o,
    output logic                      small_sign_o,
    output logic [EXP_W-1:0]          big_exp_o,
    output logic [EXP_W-1:0]          small_exp_o,
    output logic [FRAC_W:0]           big_mant_o,
    output logic [FRAC_W:0]           small_mant_o,
    output logic [EXP_W-1:0]          exp_shift_o,
    output logic                      swapped_o,
    output logic [4:0]                x_flags_o,
    output logic [4:0]                y_flags_o
);

    localparam int W = 1 + EXP_W + FRAC_W;

    // Flag bit order: {snan, qnan, inf, zero, subnormal}; all clear means normal.
    function automatic logic [4:0] classify(input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] f);
        logic e_ones;
        logic e_zero;
        logic f_zero;
        logic [4:0] flags;
        e_ones = &e;
        e_zero = ~|e;
        f_zero = ~|f;
        flags  = 5'b00000;
        if (e_ones && !f_zero) begin
            if (f[FRAC_W-1]) begin
                flags = 5'b01000;
            end else begin
                flags = 5'b10000;
            end
        end else if (e_ones) begin
            flags = 5'b00100;
        end else if (e_zero && f_zero) begin
            flags = 5'b00010;
        end else if (e_zero) begin
            flags = 5'b00001;
        end
        return flags;
    endfunction

    // A subnormal or zero exponent field behaves as exponent 1 once the hidden bit is dropped.
    function automatic logic [EXP_W-1:0] effective_exp(input logic [EXP_W-1:0] e);
        return (e == '0) ? EXP_W'(1) : e;
    endfunction

    logic          s1_valid;
    logic [W-1:0]  s1_x;
    logic [W-1:0]  s1_y;
    logic          s2_valid;
    logic          adv1;
    logic          adv2;
    logic          accept;

    logic              x_sign;
    logic              y_sign;
    logic [EXP_W-1:0]  x_exp_field;
    logic [EXP_W-1:0]  y_exp_field;
    logic [FRAC_W-1:0] x_frac;
    logic [FRAC_W-1:0] y_frac;
    logic [W-2:0]      x_mag;
    logic [W-2:0]      y_mag;
    logic [EXP_W-1:0]  x_eff_exp;
    logic [EXP_W-1:0]  y_eff_exp;
    logic [FRAC_W:0]   x_mant;
    logic [FRAC_W:0]   y_mant;
    logic              swap;
    logic              d_big_sign;
    logic              d_small_sign;
    logic [EXP_W-1:0]  d_big_exp;
    logic [EXP_W-1:0]  d_small_exp;
    logic [FRAC_W:0]   d_big_mant;
    logic [FRAC_W:0]   d_small_mant;
    logic [EXP_W-1:0]  d_shift;
    logic [4:0]        d_x_flags;
    logic [4:0]        d_y_flags;

    // Stall chain: a stage may load when it is empty or its contents move on; ready is held low during reset.
    always_comb begin
        adv2    = !s2_valid || ready_i;
        adv1    = !s1_valid || adv2;
        ready_o = adv1 && rst_n_i;
        accept  = valid_i && ready_o;
    end

    // Stage 1 captures the operand pair only on an accepted transfer.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else if (adv1) begin
            s1_valid <= valid_i;
            if (accept) begin
                s1_x <= x_i;
                s1_y <= y_i;
            end
        end
    end

    // Split the stage-1 operands into fields, classify them and order the pair by unsigned magnitude.
    always_comb begin
        x_sign       = s1_x[W-1];
        y_sign       = s1_y[W-1];
        x_exp_field  = s1_x[W-2 -: EXP_W];
        y_exp_field  = s1_y[W-2 -: EXP_W];
        x_frac       = s1_x[FRAC_W-1:0];
        y_frac       = s1_y[FRAC_W-1:0];
        x_mag        = s1_x[W-2:0];
        y_mag        = s1_y[W-2:0];
        x_eff_exp    = effective_exp(x_exp_field);
        y_eff_exp    = effective_exp(y_exp_field);
        x_mant       = {|x_exp_field, x_frac};
        y_mant       = {|y_exp_field, y_frac};
        d_x_flags    = classify(x_exp_field, x_frac);
        d_y_flags    = classify(y_exp_field, y_frac);
        swap         = SWAP_EN && (y_mag > x_mag);
        d_big_sign   = x_sign;
        d_small_sign = y_sign;
        d_big_exp    = x_eff_exp;
        d_small_exp  = y_eff_exp;
        d_big_mant   = x_mant;
        d_small_mant = y_mant;
        if (swap) begin
            d_big_sign   = y_sign;
            d_small_sign = x_sign;
            d_big_exp    = y_eff_exp;
            d_small_exp  = x_eff_exp;
            d_big_mant   = y_mant;
            d_small_mant = x_mant;
        end
        d_shift = d_big_exp - d_small_exp;
    end

    // Stage 2 holds the decoded result; it only reloads when the downstream side is not stalling.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s2_valid     <= 1'b0;
            big_sign_o   <= 1'b0;
            small_sign_o <= 1'b0;
            big_exp_o    <= '0;
            small_exp_o  <= '0;
            big_mant_o   <= '0;
            small_mant_o <= '0;
            exp_shift_o  <= '0;
            swapped_o    <= 1'b0;
            x_flags_o    <= '0;
            y_flags_o    <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                big_sign_o   <= d_big_sign;
                small_sign_o <= d_small_sign;
                big_exp_o    <= d_big_exp;
                small_exp_o  <= d_small_exp;
                big_mant_o   <= d_big_mant;
                small_mant_o <= d_small_mant;
                exp_shift_o  <= d_shift;
                swapped_o    <= swap;
                x_flags_o    <= d_x_flags;
                y_flags_o    <= d_y_flags;
            end
        end
    end

    // The output valid is simply the stage-2 occupancy flag.
    always_comb begin
        valid_o = s2_valid;
    end

endmodule
